// File: rtl/op_integrator_pkg.sv
// Shared constants, state encoding and sizing helper for the CIC integrator section.
package op_integrator_pkg;

    localparam int CIC_WIDTH  = 24;
    localparam int CIC_STAGES = 3;
    localparam int CIC_DECIM  = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        INTEG = 1'b1
    } state_t;

    // Width of the decimation counter; never narrower than one bit.
    function automatic int dcnt_w(input int decim);
        return (decim > 2) ? $clog2(decim) : 1;
    endfunction

endpackage

// File: rtl/op_integrator_if.sv
// Sample stream into the integrator and decimated stream out toward the comb section.
interface op_integrator_if
    import op_integrator_pkg::*;
#(
    parameter int WIDTH = CIC_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             lr_clk;
    logic             busy;
    logic             overrun;

    modport master (
        output in_valid, in,
        input  out, out_valid, lr_clk, busy, overrun
    );

    modport slave (
        input  in_valid, in,
        output out, out_valid, lr_clk, busy, overrun
    );

endinterface

// File: rtl/op_integrator_adder.sv
// Plain modulo-2^WIDTH combinational adder.
module op_integrator_adder #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/op_integrator.sv
// CIC integrator section: STAGES cascaded integrators on one time-shared adder,
// decimated by DECIM, with an lr_clk frame clock for the downstream comb section.
module op_integrator
    import op_integrator_pkg::*;
#(
    parameter int WIDTH  = CIC_WIDTH,
    parameter int STAGES = CIC_STAGES,
    parameter int DECIM  = CIC_DECIM
) (
    input  logic           clk,
    input  logic           rst,
    op_integrator_if.slave bus
);

    localparam int DCNT_W = dcnt_w(DECIM);
    localparam int IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_nxt;
    logic [WIDTH-1:0]  x_reg;
    logic [WIDTH-1:0]  acc [STAGES];
    logic [WIDTH-1:0]  ops [STAGES];
    logic [WIDTH-1:0]  opnd;
    logic [WIDTH-1:0]  acc_cur;
    logic [WIDTH-1:0]  sum;

    // Stage i adds the input (i=0) or the freshly updated previous stage.
    // NOTE: every variable here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        ops[0] = x_reg;
        for (int i = 1; i < STAGES; i++) begin
            ops[i] = acc[i-1];
        end
        opnd     = ops[idx];
        acc_cur  = acc[idx];
        dcnt_nxt = (dcnt == DCNT_W'(DECIM - 1)) ? '0 : dcnt + DCNT_W'(1);
    end

    op_integrator_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a   (acc_cur),
        .b   (opnd),
        .sum (sum)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            dcnt          <= '0;
            x_reg         <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.lr_clk    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
            // NOTE: the accumulators are flops, not RAM, and must start at zero for the filter to be exact.
            for (int i = 0; i < STAGES; i++) begin
                acc[i] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_reg    <= bus.in;
                        idx      <= '0;
                        state    <= INTEG;
                        bus.busy <= 1'b1;
                    end
                end
                INTEG: begin
                    acc[idx] <= sum;
                    if (bus.in_valid) begin
                        bus.overrun <= 1'b1;
                    end
                    if (idx == IDX_W'(STAGES - 1)) begin
                        state    <= IDLE;
                        idx      <= '0;
                        bus.busy <= 1'b0;
                        dcnt     <= dcnt_nxt;
                        if (dcnt == DCNT_W'(DECIM - 1)) begin
                            bus.out       <= sum;
                            bus.out_valid <= 1'b1;
                            bus.lr_clk    <= 1'b1;
                        end
                        if (dcnt_nxt == DCNT_W'(DECIM / 2)) begin
                            bus.lr_clk <= 1'b0;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_integrator.sv
// Directed bench: impulse, step, wrap, overrun and mid-sequence reset on STAGES=3,
// with one DUT at DECIM=4 and one at DECIM=2.
module tb_op_integrator;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    op_integrator_if #(.WIDTH(24)) bus4 ();
    op_integrator_if #(.WIDTH(24)) bus2 ();

    op_integrator #(.WIDTH(24), .STAGES(3), .DECIM(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    op_integrator #(.WIDTH(24), .STAGES(3), .DECIM(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one sample for a single cycle; returns in cycle T+1.
    task automatic start(input int sel, input logic [23:0] x);
        if (sel == 4) begin
            bus4.in_valid = 1'b1;
            bus4.in       = x;
        end else begin
            bus2.in_valid = 1'b1;
            bus2.in       = x;
        end
        tick();
        bus4.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
    endtask

    // Full sample; returns in cycle T+4 where out_valid would be visible.
    task automatic send(input int sel, input logic [23:0] x);
        start(sel, x);
        wait_cycles(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus4.in_valid = 1'b0;
        bus4.in       = '0;
        bus2.in_valid = 1'b0;
        bus2.in       = '0;
        tick();
        do_reset();

        check("rst_out",       bus4.out,       0);
        check("rst_out_valid", bus4.out_valid, 0);
        check("rst_lr_clk",    bus4.lr_clk,    0);
        check("rst_busy",      bus4.busy,      0);
        check("rst_overrun",   bus4.overrun,   0);
        check("rst_out2",      bus2.out,       0);

        // Impulse 1,0,0,0: last stage walks 1,3,6,10.
        send(4, 24'd1);
        check("imp_acc2_1", u_dut4.acc[2], 1);
        check("imp_lr_1",   bus4.lr_clk,   0);
        send(4, 24'd0);
        check("imp_acc2_2", u_dut4.acc[2], 3);
        send(4, 24'd0);
        check("imp_acc2_3", u_dut4.acc[2], 6);
        check("imp_ov_3",   bus4.out_valid, 0);
        start(4, 24'd0);
        check("imp_busy_T1", bus4.busy, 1);
        wait_cycles(2);
        check("imp_ov_T3",  bus4.out_valid, 0);
        check("imp_lr_T3",  bus4.lr_clk,    0);
        tick();
        check("imp_ov_T4",  bus4.out_valid, 1);
        check("imp_out",    bus4.out,       10);
        check("imp_lr_T4",  bus4.lr_clk,    1);
        check("imp_busy_T4", bus4.busy,     0);
        tick();
        check("imp_ov_T5",  bus4.out_valid, 0);
        check("imp_hold",   bus4.out,       10);

        // Wrap at DECIM=2: two 0x7FFFFF samples, then 3 and 0.
        send(2, 24'h7FFFFF);
        check("wrap_acc0_1", u_dut2.acc[0], 32'h7FFFFF);
        check("wrap_ov_1",   bus2.out_valid, 0);
        send(2, 24'h7FFFFF);
        check("wrap_acc0_2", u_dut2.acc[0], 32'hFFFFFE);
        check("wrap_out_2",  bus2.out,       32'hFFFFFC);
        check("wrap_ov_2",   bus2.out_valid, 1);
        check("wrap_overrun", bus2.overrun,  0);
        send(2, 24'h000003);
        check("wrap_acc0_3", u_dut2.acc[0], 32'h000001);
        check("wrap_acc2_3", u_dut2.acc[2], 32'h7FFFFA);
        send(2, 24'h000000);
        check("wrap_out_4",  bus2.out,       32'hFFFFF9);

        // Step of ones: outputs 20 then 120, lr_clk 1,1,0,0 across the second frame.
        do_reset();
        begin
            logic [31:0] step_acc2 [8] = '{1, 4, 10, 20, 35, 56, 84, 120};
            logic        step_lr   [8] = '{0, 0, 0, 1, 1, 0, 0, 1};
            logic        step_ov   [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
            for (int i = 0; i < 8; i++) begin
                send(4, 24'd1);
                check($sformatf("step_acc2_%0d", i), u_dut4.acc[2], step_acc2[i]);
                check($sformatf("step_lr_%0d", i),   bus4.lr_clk,   32'(step_lr[i]));
                check($sformatf("step_ov_%0d", i),   bus4.out_valid, 32'(step_ov[i]));
            end
        end
        check("step_out", bus4.out, 120);

        // Overrun: second strobe at T+1 is dropped, flag sticks, T+4 accepted.
        do_reset();
        start(4, 24'd7);
        bus4.in_valid = 1'b1;
        bus4.in       = 24'd100;
        tick();
        bus4.in_valid = 1'b0;
        check("ovr_flag_T2", bus4.overrun, 1);
        wait_cycles(2);
        check("ovr_acc0", u_dut4.acc[0], 7);
        check("ovr_acc2", u_dut4.acc[2], 7);
        check("ovr_busy", bus4.busy,     0);
        send(4, 24'd1);
        check("ovr_acc0_next", u_dut4.acc[0], 8);
        check("ovr_acc2_next", u_dut4.acc[2], 22);
        check("ovr_sticky",    bus4.overrun,  1);

        // Mid-sequence reset at T+2 clears everything at once.
        start(4, 24'd9);
        tick();
        rst = 1'b1;
        #1;
        check("mid_acc0",    u_dut4.acc[0], 0);
        check("mid_acc1",    u_dut4.acc[1], 0);
        check("mid_acc2",    u_dut4.acc[2], 0);
        check("mid_busy",    bus4.busy,     0);
        check("mid_overrun", bus4.overrun,  0);
        tick();
        rst = 1'b0;
        tick();
        send(4, 24'd5);
        check("mid_acc2_1", u_dut4.acc[2], 5);
        check("mid_ov_1",   bus4.out_valid, 0);
        send(4, 24'd0);
        send(4, 24'd0);
        send(4, 24'd0);
        check("mid_out",    bus4.out,       50);
        check("mid_ov_4",   bus4.out_valid, 1);
        check("mid_lr_4",   bus4.lr_clk,    1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
